uart_tx_serializer: RTL
=======================

// Module: uart_tx_serializer
// PURPOSE
//  Serialises one DATA_BITS word per request onto the UART Tx line: start bit, data MSB first,
//  optional even-parity bit, STOP_BITS stop bits. Transmit half of the UART; its frame is bit-exact
//  with what the receiver/FIFO path accepts on Rx. Bit timing comes from an internal baud divider.
// PARAMETERS
//  SYSCLK_RATE  100000000  system clock frequency, Hz
//  BAUD_RATE    9600       line rate, bits/s; DIV = SYSCLK_RATE/BAUD_RATE (integer, >=2)
//  DATA_BITS    8          data bits per frame, 5..8
//  PARITY_BIT   1          1: even-parity bit (XOR of data) follows data; 0: no parity bit
//  STOP_BITS    2          stop bits, 1..2
// PORTS
//  SysClk          in   1          system clock, all state on rising edge
//  Rst             in   1          asynchronous, active-high reset
//  Tx_Data         in   DATA_BITS  word to send; sampled only on accept
//  Transmit_Start  in   1          level request; accepted in IDLE
//  CTS             in   1          clear-to-send from far end (used only with UART_TX_CTS_EN)
//  Tx              out  1          serial line, idle high
//  Tx_Busy         out  1          high from accept through end of last stop bit
//  Tx_Done         out  1          one-cycle pulse on the cycle the frame completes
// BEHAVIOUR
//  - Reset: Tx=1, Tx_Busy=0, Tx_Done=0, state IDLE, baud/bit counters 0; reset mid-frame aborts
//    at once (Tx forced high asynchronously), no Tx_Done.
//  - Frame length NBITS = 1 + DATA_BITS + PARITY_BIT + STOP_BITS; each bit held exactly DIV cycles;
//    frame = NBITS*DIV cycles.
//  - FSM IDLE -> START -> DATA -> PARITY (skipped if PARITY_BIT=0) -> STOP -> IDLE.
//  - Accept: rising edge in IDLE with Transmit_Start=1 (and CTS=1 when gated). On that edge: shift
//    reg <= Tx_Data, parity <= ^Tx_Data, Tx <= 0, Tx_Busy <= 1, baud counter <= 0.
//    Latency request->start bit = 1 cycle.
//  - Baud counter counts 0..DIV-1; at DIV-1 wraps to 0 and advances one bit; data bit counter
//    counts DATA_BITS-1 down to 0 (MSB first); stop counter counts STOP_BITS.
//  - Tx is a registered output, glitch-free; Tx_Data changes after accept are ignored.
//  - End of frame: on the edge ending the last stop bit: state IDLE, Tx_Busy <= 0, Tx_Done <= 1
//    for one cycle, Tx stays 1.
//  - Back-to-back: if Transmit_Start is still high on that same edge, next frame is accepted on
//    the following edge (one idle SysClk between frames, Tx high). Requester drops
//    Transmit_Start once Tx_Busy is seen to avoid resending.
//  - Transmit_Start during Busy: ignored, not queued.
//  - Parity computed over the DATA_BITS used only; unused upper bits absent.
// CONFIGURATION
//  UART_TX_CTS_EN defined: accept also requires CTS=1; CTS falling mid-frame does not abort,
//    frame completes; new frame waits in IDLE for CTS=1.
//  UART_TX_CTS_EN undefined: CTS port present but ignored; accept on Transmit_Start alone.
// TESTING  (SYSCLK_RATE=1600, BAUD_RATE=100 -> DIV=16; DATA_BITS=8, PARITY_BIT=1, STOP_BITS=2)
//  1 Tx_Data=8'hA5, pulse Transmit_Start -> Tx sampled mid-bit = 0,1,0,1,0,0,1,0,1,0,1,1
//    (parity 0); Tx_Busy high 192 cycles; Tx_Done one pulse at cycle 193.
//  2 Tx_Data=8'h01 -> parity bit 1; 8'hFF -> parity 0; bit widths exactly 16 cycles each.
//  3 Hold Transmit_Start high, Tx_Data 8'h3C then 8'hC3 -> two frames, exactly 1 idle cycle
//    between, second frame carries 8'hC3.
//  4 Assert Rst at cycle 50 of a frame -> Tx=1, Tx_Busy=0 immediately, no Tx_Done; next request
//    sends a full clean frame.
//  5 Change Tx_Data to 8'h00 mid-frame of 8'h5A -> line still carries 8'h5A.
//  6 UART_TX_CTS_EN: CTS=0 with Transmit_Start=1 -> Tx stays 1, Busy 0; raise CTS -> start bit
//    next cycle; drop CTS mid-frame -> frame completes.

Source files
------------

// File: rtl/uart_tx_serializer.sv
// -----------------------------------------------------------------------------
// uart_tx_serializer
//
// Purpose
//   Transmit half of the UART. Serialises one DATA_BITS word per accepted
//   request onto the Tx line in this order: a start bit (0), the data MSB
//   first, an optional even-parity bit (XOR of the data bits) and STOP_BITS
//   stop bits (1). The frame is bit-exact with what the receive path accepts.
//   Bit timing comes from an internal baud divider:
//   DIV = SYSCLK_RATE / BAUD_RATE, and every bit is held for exactly DIV
//   SysClk cycles.
//
// Parameters
//   SYSCLK_RATE  system clock frequency in Hz
//   BAUD_RATE    line rate in bits/s (SYSCLK_RATE/BAUD_RATE must be >= 2)
//   DATA_BITS    data bits per frame, 5..8
//   PARITY_BIT   1 = even-parity bit after the data, 0 = no parity bit
//   STOP_BITS    stop bits per frame, 1..2
//
// Ports
//   SysClk          in   system clock; all state changes on its rising edge
//   Rst             in   asynchronous active-high reset; aborts any frame
//   Tx_Data         in   word to send; sampled only on the accepting edge
//   Transmit_Start  in   level request; accepted only while idle
//   CTS             in   clear-to-send from the far end (see macro below)
//   Tx              out  registered serial line, idle high
//   Tx_Busy         out  high from the accept through the last stop bit
//   Tx_Done         out  one-cycle pulse on the edge that ends the frame
//
// Build option
//   UART_TX_CTS_EN  when defined, a request is accepted only while CTS=1.
//                   CTS falling mid-frame does not abort the frame. When
//                   undefined, CTS is present but ignored.
// -----------------------------------------------------------------------------
module uart_tx_serializer #(
    parameter int SYSCLK_RATE = 100000000,
    parameter int BAUD_RATE   = 9600,
    parameter int DATA_BITS   = 8,
    parameter int PARITY_BIT  = 1,
    parameter int STOP_BITS   = 2
) (
    input  logic                 SysClk,
    input  logic                 Rst,
    input  logic [DATA_BITS-1:0] Tx_Data,
    input  logic                 Transmit_Start,
    input  logic                 CTS,
    output logic                 Tx,
    output logic                 Tx_Busy,
    output logic                 Tx_Done
);

    localparam int DIV   = SYSCLK_RATE / BAUD_RATE;
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int BIT_W = $clog2(DATA_BITS);

    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(DIV - 1);
    localparam logic [BIT_W-1:0] BIT_MSB   = BIT_W'(DATA_BITS - 1);
    localparam logic             STOP_LAST = 1'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t                 state_q,   state_d;
    logic [CNT_W-1:0]       baudCnt_q, baudCnt_d;
    logic [BIT_W-1:0]       bitCnt_q,  bitCnt_d;
    logic                   stopCnt_q, stopCnt_d;
    logic [DATA_BITS-1:0]   shift_q,   shift_d;
    logic                   parity_q,  parity_d;
    logic                   tx_q,      tx_d;
    logic                   busy_q,    busy_d;
    logic                   done_q,    done_d;

    logic                   ctsOk;
    logic                   bitEnd;

    // Flow-control gate applied to new requests only; an active frame
    // always runs to completion regardless of CTS.
`ifdef UART_TX_CTS_EN
    assign ctsOk = CTS;
`else
    logic unusedCts;
    assign unusedCts = CTS;
    assign ctsOk     = 1'b1;
`endif

    // Last cycle of the current bit period: the next edge moves to the next bit.
    assign bitEnd = (baudCnt_q == BAUD_LAST);

    // Next-state logic. The line value is derived from the *next* state so
    // that Tx is a plain flop output and changes exactly on bit boundaries.
    always_comb begin
        state_d   = state_q;
        baudCnt_d = baudCnt_q;
        bitCnt_d  = bitCnt_q;
        stopCnt_d = stopCnt_q;
        shift_d   = shift_q;
        parity_d  = parity_q;
        busy_d    = busy_q;
        done_d    = 1'b0;

        if (state_q != IDLE) begin
            baudCnt_d = bitEnd ? '0 : baudCnt_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (Transmit_Start && ctsOk) begin
                    state_d   = START;
                    shift_d   = Tx_Data;
                    parity_d  = ^Tx_Data;
                    busy_d    = 1'b1;
                    baudCnt_d = '0;
                    bitCnt_d  = BIT_MSB;
                    stopCnt_d = 1'b0;
                end
            end

            START: begin
                if (bitEnd) begin
                    state_d  = DATA;
                    bitCnt_d = BIT_MSB;
                end
            end

            DATA: begin
                if (bitEnd) begin
                    if (bitCnt_q == '0) begin
                        state_d   = (PARITY_BIT != 0) ? PARITY : STOP;
                        stopCnt_d = 1'b0;
                    end else begin
                        bitCnt_d = bitCnt_q - 1'b1;
                    end
                end
            end

            PARITY: begin
                if (bitEnd) begin
                    state_d   = STOP;
                    stopCnt_d = 1'b0;
                end
            end

            STOP: begin
                if (bitEnd) begin
                    if (stopCnt_q == STOP_LAST) begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        stopCnt_d = stopCnt_q + 1'b1;
                    end
                end
            end

            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase

        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[bitCnt_d];
            PARITY:  tx_d = parity_d;
            default: tx_d = 1'b1;
        endcase
    end

    // State register. Reset drives the line high immediately so a frame in
    // flight is cut off without any further low bits and without Tx_Done.
    always_ff @(posedge SysClk or posedge Rst) begin
        if (Rst) begin
            state_q   <= IDLE;
            baudCnt_q <= '0;
            bitCnt_q  <= '0;
            stopCnt_q <= 1'b0;
            shift_q   <= '0;
            parity_q  <= 1'b0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            baudCnt_q <= baudCnt_d;
            bitCnt_q  <= bitCnt_d;
            stopCnt_q <= stopCnt_d;
            shift_q   <= shift_d;
            parity_q  <= parity_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign Tx      = tx_q;
    assign Tx_Busy = busy_q;
    assign Tx_Done = done_q;

endmodule
